// File: rtl/rx_packet_buffer.sv
// rx_packet_buffer: serialises strobed multi-channel frames into one circular buffer,
// signals whole packets and caps each read burst at PKT_WORDS words.
module rx_packet_buffer #(
  parameter int WIDTH     = 16,
  parameter int MAX_CH    = 8,
  parameter int DEPTH     = 1024,
  parameter int PKT_WORDS = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                channels,
  input  logic                      gate_enable,
  input  logic                      rxstrobe,
  input  logic [MAX_CH*WIDTH-1:0]   ch_data,
  input  logic                      rd,
  input  logic                      clear_status,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      packet_rdy,
  output logic                      overflow,
  output logic                      underrun,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = MAX_CH > 1 ? $clog2(MAX_CH) : 1;
  localparam int BW = $clog2(PKT_WORDS) + 1;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [MAX_CH*WIDTH-1:0] cap_q, cap_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [BW-1:0]           burst_q, burst_d;
  logic [3:0]              ch_q, ch_d, n;
  logic [WIDTH-1:0]        rd_data_q, rd_data_d;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic packet_rdy_q, packet_rdy_d, overflow_q, overflow_d, underrun_q, underrun_d;
  logic stb, busy, last, flush, can_take, fits, accept, rd_ok, rd_empty;

  always_comb begin
    n = ((channels == 4'd1) || (channels == 4'd2) || (channels == 4'd4) || (channels == 4'd8))
        && (32'(channels) <= MAX_CH) ? channels : 4'd1;
    busy = state_q == WRITE;
    last = busy && (4'(idx_q) == ch_q - 4'd1);
    flush = !busy && (n != ch_q);
    stb = rxstrobe && gate_enable;
    // the last word of a frame may overlap the next accept, giving one frame per N cycles
    can_take = busy ? (last && (n == ch_q)) : !flush;
    fits = 32'(level_q) + 32'(busy) + 32'(ch_q) <= DEPTH;
    accept = stb && can_take && fits;
    rd_ok = rd && !flush && (level_q != '0) && (32'(burst_q) < PKT_WORDS);
    rd_empty = rd && !flush && (level_q == '0) && (32'(burst_q) < PKT_WORDS);
    state_d = accept ? WRITE : last ? IDLE : state_q;
    idx_d = accept ? '0 : busy ? idx_q + IW'(1) : idx_q;
    cap_d = accept ? ch_data : cap_q;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(busy);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_ok);
    level_d = flush ? '0 : level_q + LW'(busy) - LW'(rd_ok);
    burst_d = (flush || !rd) ? '0 : burst_q + BW'(rd_ok);
    ch_d = flush ? n : ch_q;
    rd_data_d = rd_ok ? mem[rd_ptr_q] : rd_data_q;
    packet_rdy_d = 32'(level_q) >= PKT_WORDS;
    overflow_d = (stb && !flush && !accept) || (overflow_q && !clear_status);
    underrun_d = rd_empty || (underrun_q && !clear_status);
  end

  always_ff @(posedge clk)
    if (busy) mem[wr_ptr_q] <= cap_q[idx_q*WIDTH +: WIDTH];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cap_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      burst_q      <= '0;
      ch_q         <= 4'd1;
      rd_data_q    <= '0;
      packet_rdy_q <= 1'b0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cap_q        <= cap_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      burst_q      <= burst_d;
      ch_q         <= ch_d;
      rd_data_q    <= rd_data_d;
      packet_rdy_q <= packet_rdy_d;
      overflow_q   <= overflow_d;
      underrun_q   <= underrun_d;
    end

  assign rd_data    = rd_data_q;
  assign packet_rdy = packet_rdy_q;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;
  assign level      = level_q;
endmodule

// File: tb/tb_rx_packet_buffer.sv
// tb_rx_packet_buffer: random and directed frames checked against a queue-based model.
module tb_rx_packet_buffer;
  localparam int WIDTH = 16, MAX_CH = 8, DEPTH = 1024, PKT = 256;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] channels = 4'd1;
  logic gate_enable = 1'b1, rxstrobe = 1'b0, rd = 1'b0, clear_status = 1'b0;
  logic [MAX_CH*WIDTH-1:0] ch_data = '0;
  logic [WIDTH-1:0] rd_data;
  logic packet_rdy, overflow, underrun;
  logic [10:0] level;

  rx_packet_buffer #(.WIDTH(WIDTH), .MAX_CH(MAX_CH), .DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
    .clk(clk), .reset(reset), .channels(channels), .gate_enable(gate_enable),
    .rxstrobe(rxstrobe), .ch_data(ch_data), .rd(rd), .clear_status(clear_status),
    .rd_data(rd_data), .packet_rdy(packet_rdy), .overflow(overflow),
    .underrun(underrun), .level(level));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [WIDTH-1:0] q[$], pend[$];
  int m_ch = 1, burst = 0;
  logic [WIDTH-1:0] m_rd = '0;
  bit m_prdy = 0, m_ovf = 0, m_und = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int dec(logic [3:0] c);
    return (c == 1 || c == 2 || c == 4 || c == 8) ? int'(c) : 1;
  endfunction

  // advances the model across one clock edge using the inputs now applied
  task automatic model_step();
    int nn = dec(channels);
    int lvl = q.size();
    bit busy = pend.size() > 0;
    bit flush = !busy && nn != m_ch;
    bit stb = rxstrobe && gate_enable;
    bit can = busy ? (pend.size() == 1 && nn == m_ch) : !flush;
    bit acc = stb && can && (lvl + (busy ? 1 : 0) + m_ch <= DEPTH);
    bit rdok = rd && !flush && lvl > 0 && burst < PKT;
    bit und = rd && !flush && lvl == 0 && burst < PKT;
    m_prdy = lvl >= PKT;
    m_ovf = (stb && !flush && !acc) ? 1'b1 : clear_status ? 1'b0 : m_ovf;
    m_und = und ? 1'b1 : clear_status ? 1'b0 : m_und;
    if (flush) begin
      q.delete(); burst = 0; m_ch = nn;
    end else begin
      if (rdok) begin m_rd = q.pop_front(); burst++; end
      if (!rd) burst = 0;
      if (busy) q.push_back(pend.pop_front());
    end
    if (acc) for (int k = 0; k < m_ch; k++) pend.push_back(ch_data[k*WIDTH +: WIDTH]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("level", level, q.size());
    check("packet_rdy", packet_rdy, m_prdy);
    check("overflow", overflow, m_ovf);
    check("underrun", underrun, m_und);
    check("rd_data", rd_data, m_rd);
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      rd = 1'b1; ticks(260);
      rd = 1'b0; tick();
    end
  endtask

  task automatic rand_data();
    ch_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_level", level, 0);
    check("rst_pkt_rdy", packet_rdy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underrun", underrun, 0);
    check("rst_rd_data", rd_data, 0);
    q.delete(); pend.delete(); burst = 0; m_ch = 1; m_rd = '0;
    m_prdy = 0; m_ovf = 0; m_und = 0;
    rxstrobe = 1'b0; rd = 1'b0; clear_status = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ch_opts [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd15};
    logic [WIDTH-1:0] w0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_pkt_rdy", packet_rdy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    tick();
    // single-channel ramp, then an over-long read burst
    for (int i = 0; i < 256; i++) begin
      rand_data(); ch_data[WIDTH-1:0] = 16'(i); rxstrobe = 1'b1; tick();
    end
    rxstrobe = 1'b0; ticks(3);
    rd = 1'b1; ticks(300);
    check("ramp_hold", rd_data, 255);
    rd = 1'b0; tick();
    // eight channels at full rate, then at half spacing
    channels = 4'd8; tick();
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < MAX_CH; k++) ch_data[k*WIDTH +: WIDTH] = 16'(k*4096 + f);
      rxstrobe = 1'b1; tick();
      rxstrobe = 1'b0; ticks(f < 10 ? 7 : 3);
    end
    ticks(8);
    check("spacing_ovf", overflow, 1);
    drain();
    clear_status = 1'b1; tick(); clear_status = 1'b0; tick();
    // fill completely, read four, then a frame that cannot fit
    for (int f = 0; f < 128; f++) begin
      rand_data(); rxstrobe = 1'b1; tick(); rxstrobe = 1'b0; ticks(7);
    end
    ticks(2);
    rd = 1'b1; ticks(4); rd = 1'b0; tick();
    rand_data(); rxstrobe = 1'b1; tick(); rxstrobe = 1'b0; ticks(2);
    check("full_level", level, 1020);
    check("full_ovf", overflow, 1);
    clear_status = 1'b1; tick(); clear_status = 1'b0; tick();
    drain();
    // concurrent write and read around level 100
    channels = 4'd1; tick();
    for (int i = 0; i < 100; i++) begin rand_data(); rxstrobe = 1'b1; tick(); end
    rxstrobe = 1'b0; ticks(2);
    rd = 1'b1;
    for (int i = 0; i < 50; i++) begin rand_data(); rxstrobe = 1'b1; tick(); end
    rxstrobe = 1'b0; rd = 1'b0; ticks(2);
    drain();
    // channel change during a frame is deferred until it completes
    channels = 4'd2; tick();
    rand_data(); rxstrobe = 1'b1; tick();
    rxstrobe = 1'b0; channels = 4'd4; ticks(5);
    // read on empty buffer
    rd = 1'b1; tick(); rd = 1'b0; tick();
    check("empty_underrun", underrun, 1);
    clear_status = 1'b1; tick(); clear_status = 1'b0; tick();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) channels = ch_opts[$urandom_range(0, 7)];
      rand_data();
      rxstrobe = $urandom_range(0, 2) == 0;
      gate_enable = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) rd = !rd;
      clear_status = $urandom_range(0, 49) == 0;
      tick();
    end
    rxstrobe = 1'b0; rd = 1'b0; clear_status = 1'b0; gate_enable = 1'b1; ticks(10);
    // reset mid-frame, then confirm a clean frame starts at channel 0
    channels = 4'd8; tick();
    rand_data(); rxstrobe = 1'b1; tick(); rxstrobe = 1'b0; ticks(2);
    do_reset();
    tick();
    rand_data(); w0 = ch_data[WIDTH-1:0]; rxstrobe = 1'b1; tick();
    rxstrobe = 1'b0; ticks(9);
    rd = 1'b1; tick(); rd = 1'b0;
    check("first_after_reset", rd_data, w0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rx_packet_buffer.md
# rx_packet_buffer

Parametrised single-clock successor to the multi-FIFO RX buffer. It takes one strobed frame of up to MAX_CH DSP channel samples and serialises the frame, channel 0 first, into one shared circular buffer, so channel interleaving is held by address rather than by a per-channel read selector. It raises packet_rdy when a full USB packet is buffered and enforces a hard PKT_WORDS read-burst limit (the 257-read fix, generalised). It sits between the DDC/decimator outputs and the FX2 read-side interface logic.

## Interface
- WIDTH, 16, sample width in bits.
- MAX_CH, 8, maximum channel count; one of 1, 2, 4, 8.
- DEPTH, 1024, buffer depth in words; power of 2, at least 2*PKT_WORDS.
- PKT_WORDS, 256, words per USB packet; power of 2, multiple of MAX_CH.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- channels  in  4  active channel count (1, 2, 4, 8); any other value, or any value greater than MAX_CH, selects 1.
- gate_enable  in  1  qualifies rxstrobe.
- rxstrobe  in  1  one-cycle strobe marking a valid sample frame.
- ch_data  in  MAX_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- rd  in  1  read burst request, held high for the whole burst.
- clear_status  in  1  synchronous clear of the sticky flags.
- rd_data  out  WIDTH  read data, registered.
- packet_rdy  out  1  at least PKT_WORDS words are buffered.
- overflow  out  1  sticky; a frame was dropped.
- underrun  out  1  sticky; a read was attempted while the buffer was empty.
- level  out  log2(DEPTH)+1  current word count.

## Operation
- Reset values: every output, pointers, counters and the FSM return to 0/IDLE.
- N is the decoded channel count. ch_reg holds the registered copy of N.
- Write FSM states are IDLE and WRITE.
- IDLE: a frame is accepted when rxstrobe && gate_enable && (DEPTH - level) >= N.
  - On accept: ch_data is latched into the capture register, the write index is set to 0, and the FSM moves to WRITE.
  - If the space check fails, the frame is dropped whole, overflow is set, and the FSM stays in IDLE.
- WRITE: one word per cycle, capture[idx] is written to mem[wr_ptr]; wr_ptr and idx increment. After word N-1 the FSM returns to IDLE.
- An rxstrobe && gate_enable arriving while in WRITE is dropped and sets overflow. The frame in progress completes unaffected.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- level counts +1 per write and -1 per accepted read; a simultaneous write and read leaves it unchanged.
- Accepted read: rd && (level != 0) && (burst_cnt < PKT_WORDS).
  - An accepted read registers mem[rd_ptr] into rd_data and increments rd_ptr and burst_cnt.
- burst_cnt is cleared on any cycle with rd low.
- Once burst_cnt reaches PKT_WORDS, further rd-high cycles are ignored: rd_data holds and no status changes.
- rd && (level == 0) && (burst_cnt < PKT_WORDS) sets underrun; rd_data holds.
- packet_rdy is registered as (level >= PKT_WORDS).
- clear_status clears overflow and underrun. If a set event occurs in the same cycle, the set wins.
- Channel change: if the decoded channels value differs from ch_reg while the FSM is IDLE, the buffer is flushed.
  - Flush: pointers, level and burst_cnt go to 0, ch_reg updates, and packet_rdy deasserts on the next edge. Sticky flags are kept.
  - While in WRITE, the change is deferred until the FSM returns to IDLE.
  - An rxstrobe in the flush cycle is dropped without setting overflow.

## Timing
- Frame accepted at edge T: word k is written at edge T+1+k. level reaches its old value +N at edge T+N. The earliest next accept is at edge T+N.
- Read latency is 1: rd sampled high at edge T puts the word on rd_data after edge T.
- packet_rdy lags level by one cycle in both directions.
- overflow and underrun assert one edge after the causing event.
- Sustained input rate: one frame per N cycles. A strobe spacing shorter than N always drops frames.
- Asynchronous reset mid-burst or mid-frame: all state clears immediately. The partial frame is discarded, and the first word after reset is a channel-0 word.

## Test plan
- Single channel, DEPTH=1024, PKT_WORDS=256: 256 strobes with ramp data 0..255 -> packet_rdy high one cycle after level=256. A 300-cycle rd burst returns 0..255, then rd_data holds 255 and level=0.
- channels=8, strobe every 8 cycles, channel k = 16'hk000+frame -> read order is ch0..ch7 per frame. Strobe spacing 4 -> every second frame dropped and overflow=1.
- Fill the buffer to level=1020 with channels=8, then strobe -> frame dropped, level stays 1020, overflow=1. clear_status -> overflow=0.
- Simultaneous write and accepted read for 50 cycles at level=100 -> level stays 100; pointers wrap past 1023 with data intact.
- Change channels from 2 to 4 mid-WRITE -> frame completes; flush the cycle after IDLE, giving level=0 and packet_rdy=0 after one edge.
- rd on an empty buffer -> underrun=1 and rd_data unchanged. Assert reset mid-frame -> all outputs 0 asynchronously.
